// File: rtl/cond_stream_pkg.sv
// Shared types and size helpers for the conditional-select streaming wrapper.
package cond_stream_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        SEND    = 2'd2
    } state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int calc_in_w(input int data_w);
        return 4 * data_w + 2;
    endfunction

    function automatic int calc_out_w(input int data_w);
        return 3 * data_w;
    endfunction

    function automatic int calc_in_beats(input int data_w, input int beat_w);
        return ceil_div(calc_in_w(data_w), beat_w);
    endfunction

    function automatic int calc_out_beats(input int data_w, input int beat_w);
        return ceil_div(calc_out_w(data_w), beat_w);
    endfunction

    // Bits needed to hold values 0 .. n-1 (at least one bit).
    function automatic int calc_cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/cond_stream_wrapper_kernel.sv
// Purely combinational conditional-select kernel: two muxes and a
// constant-or-sum selector, all unsigned and truncated to DATA_W.
module cond_select_kernel #(
    parameter int              DATA_W    = 8,
    parameter logic [DATA_W-1:0] CONST_VAL = 8'hA5
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    input  logic [DATA_W-1:0] d_i,
    input  logic              sel1_i,
    input  logic              sel2_i,
    output logic [DATA_W-1:0] cond1_o,
    output logic [DATA_W-1:0] cond2_o,
    output logic [DATA_W-1:0] cond3_o
);

    logic [DATA_W-1:0] sum;

    assign sum     = a_i + b_i;
    assign cond1_o = sel1_i ? a_i : b_i;
    assign cond2_o = sel2_i ? c_i : d_i;
    assign cond3_o = (sel1_i & sel2_i) ? CONST_VAL : sum;

endmodule

// File: rtl/cond_stream_wrapper.sv
// Deserialises stimulus beats, evaluates cond_select_kernel once, and streams
// the packed results back out. Define COND_STREAM_WRAPPER_CHK_EN to append an XOR checksum beat.
module cond_stream_wrapper
    import cond_stream_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                BEAT_W    = 16,
    parameter logic [DATA_W-1:0] CONST_VAL = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BEAT_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [BEAT_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy
);

    localparam int IN_W      = calc_in_w(DATA_W);
    localparam int OUT_W     = calc_out_w(DATA_W);
    localparam int IN_BEATS  = calc_in_beats(DATA_W, BEAT_W);
    localparam int OUT_BEATS = calc_out_beats(DATA_W, BEAT_W);
`ifdef COND_STREAM_WRAPPER_CHK_EN
    localparam int SEND_BEATS = OUT_BEATS + 1;
`else
    localparam int SEND_BEATS = OUT_BEATS;
`endif
    localparam int CNT_N = (IN_BEATS > SEND_BEATS) ? IN_BEATS : SEND_BEATS;
    localparam int CNT_W = calc_cnt_w(CNT_N);
    localparam logic [CNT_W-1:0] IN_LAST   = CNT_W'(IN_BEATS - 1);
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(SEND_BEATS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IN_W-1:0]   stim_q;
    logic [OUT_W-1:0]  res_q;
    logic [OUT_W-1:0]  res_d;
    logic              stim_we;
    logic              res_we;
    logic [DATA_W-1:0] cond1, cond2, cond3;
    logic [BEAT_W-1:0] res_beats [OUT_BEATS];
    logic [BEAT_W-1:0] send_beat;

    cond_select_kernel #(
        .DATA_W   (DATA_W),
        .CONST_VAL(CONST_VAL)
    ) u_kernel (
        .a_i    (stim_q[IN_W-1 -: DATA_W]),
        .b_i    (stim_q[IN_W-1-DATA_W -: DATA_W]),
        .c_i    (stim_q[IN_W-1-2*DATA_W -: DATA_W]),
        .d_i    (stim_q[IN_W-1-3*DATA_W -: DATA_W]),
        .sel1_i (stim_q[1]),
        .sel2_i (stim_q[0]),
        .cond1_o(cond1),
        .cond2_o(cond2),
        .cond3_o(cond3)
    );

    assign res_d = {cond1, cond2, cond3};

    // Slice the result into beats; the top beat is zero-padded above OUT_W.
    for (genvar gi = 0; gi < OUT_BEATS; gi++) begin : g_beat
        if ((gi + 1) * BEAT_W <= OUT_W) begin : g_full
            assign res_beats[gi] = res_q[gi*BEAT_W +: BEAT_W];
        end else begin : g_pad
            assign res_beats[gi] = BEAT_W'(res_q[OUT_W-1:gi*BEAT_W]);
        end
    end

`ifdef COND_STREAM_WRAPPER_CHK_EN
    logic [BEAT_W-1:0] chk_beat;

    always_comb begin
        chk_beat = '0;
        for (int i = 0; i < OUT_BEATS; i++) begin
            chk_beat = chk_beat ^ res_beats[i];
        end
    end
`endif

    always_comb begin
        send_beat = '0;
        for (int i = 0; i < OUT_BEATS; i++) begin
            if (cnt_q == CNT_W'(i)) send_beat = res_beats[i];
        end
`ifdef COND_STREAM_WRAPPER_CHK_EN
        if (cnt_q == CNT_W'(OUT_BEATS)) send_beat = chk_beat;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        busy    = 1'b1;
        stim_we = 1'b0;
        res_we  = 1'b0;
        case (state_q)
            COLLECT: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    stim_we = 1'b1;
                    if (cnt_q == IN_LAST) begin
                        cnt_d   = '0;
                        state_d = EVAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            EVAL: begin
                res_we  = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                m_valid = 1'b1;
                m_data  = send_beat;
                m_last  = (cnt_q == SEND_LAST);
                if (m_ready) begin
                    if (cnt_q == SEND_LAST) begin
                        cnt_d   = '0;
                        state_d = COLLECT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            stim_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Stimulus bit i lives in beat i/BEAT_W at lane i%BEAT_W; pad lanes are dropped.
            if (stim_we) begin
                for (int i = 0; i < IN_W; i++) begin
                    if (cnt_q == CNT_W'(i / BEAT_W)) stim_q[i] <= s_data[i % BEAT_W];
                end
            end
            if (res_we) res_q <= res_d;
        end
    end

endmodule
